// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin arbiter onto a shared bus chain
// One transaction in flight; responses are matched by address and abandoned after TIMEOUT idle WAIT cycles.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] a_addr,
    input  logic [15:0] a_data,
    input  logic        a_rw,
    input  logic        a_valid,
    output logic        a_ready,
    output logic [15:0] a_res_data,
    output logic        a_res_valid,

    input  logic [15:0] b_addr,
    input  logic [15:0] b_data,
    input  logic        b_rw,
    input  logic        b_valid,
    output logic        b_ready,
    output logic [15:0] b_res_data,
    output logic        b_res_valid,

    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,

    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,

    output logic        timeout_o
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0] CNT_LIMIT = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state_q;
    logic           last_b_q;
    logic           owner_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]    addr_q;
    logic [15:0]    wdata_q;
    logic           rw_q;
    logic           valid_q;
    logic           a_res_valid_q;
    logic [15:0]    a_res_data_q;
    logic           b_res_valid_q;
    logic [15:0]    b_res_data_q;
    logic           timeout_q;

    logic           grant_a;
    logic           grant_b;
    logic           accept_a;
    logic           accept_b;
    logic           in_flight;
    logic           resp_hit;
    logic [15:0]    resp_data;
    logic [CNT_W:0] cnt_inc;
    logic           expire;

    // Round-robin: on contention the requester not served last wins.
    assign grant_a  = a_valid & (~b_valid | last_b_q);
    assign grant_b  = b_valid & (~a_valid | ~last_b_q);
    assign a_ready  = ~rst & (state_q == IDLE) & grant_a;
    assign b_ready  = ~rst & (state_q == IDLE) & grant_b;
    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;

    assign in_flight = (state_q == ISSUE) | (state_q == WAIT);
    assign resp_hit  = in_flight & valid_i & (addr_i == addr_q);
    assign resp_data = rw_i ? wdata_i : rdata_i;

    // The increment that lands on TIMEOUT ends the wait on the next cycle.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign expire  = (cnt_inc >= CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_b_q      <= 1'b1;
            owner_b_q     <= 1'b0;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rw_q          <= 1'b0;
            valid_q       <= 1'b0;
            a_res_valid_q <= 1'b0;
            a_res_data_q  <= '0;
            b_res_valid_q <= 1'b0;
            b_res_data_q  <= '0;
            timeout_q     <= 1'b0;
        end else begin
            valid_q       <= 1'b0;
            a_res_valid_q <= 1'b0;
            b_res_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept_a || accept_b) begin
                        addr_q    <= accept_a ? a_addr : b_addr;
                        wdata_q   <= accept_a ? a_data : b_data;
                        rw_q      <= accept_a ? a_rw   : b_rw;
                        owner_b_q <= accept_b;
                        last_b_q  <= accept_b;
                        valid_q   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // A response beats a timeout expiring in the same cycle.
                    if (resp_hit) begin
                        if (owner_b_q) begin
                            b_res_valid_q <= 1'b1;
                            b_res_data_q  <= resp_data;
                        end else begin
                            a_res_valid_q <= 1'b1;
                            a_res_data_q  <= resp_data;
                        end
                        state_q <= IDLE;
                    end else if (state_q == ISSUE) begin
                        state_q <= WAIT;
                    end else if (expire) begin
                        if (owner_b_q) begin
                            b_res_valid_q <= 1'b1;
                            b_res_data_q  <= '0;
                        end else begin
                            a_res_valid_q <= 1'b1;
                            a_res_data_q  <= '0;
                        end
                        timeout_q <= 1'b1;
                        cnt_q     <= cnt_inc[CNT_W-1:0];
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc[CNT_W-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rw_o        = rw_q;
    assign valid_o     = valid_q;
    assign rdata_o     = '0;
    assign a_res_valid = a_res_valid_q;
    assign a_res_data  = a_res_data_q;
    assign b_res_valid = b_res_valid_q;
    assign b_res_data  = b_res_data_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
// A 32-deep memory chain with selectable latency closes the bus loop; stray beats can be injected.
module tb_bus_arbiter;

    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a_addr, a_data, b_addr, b_data;
    logic        a_rw, a_valid, b_rw, b_valid;
    logic        a_ready, a_res_valid, b_ready, b_res_valid;
    logic [15:0] a_res_data, b_res_data;
    logic [15:0] addr_o, wdata_o, rdata_o, addr_i, wdata_i, rdata_i;
    logic        rw_o, valid_o, rw_i, valid_i, timeout_o;

    bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_data(a_data), .a_rw(a_rw), .a_valid(a_valid), .a_ready(a_ready),
        .a_res_data(a_res_data), .a_res_valid(a_res_valid),
        .b_addr(b_addr), .b_data(b_data), .b_rw(b_rw), .b_valid(b_valid), .b_ready(b_ready),
        .b_res_data(b_res_data), .b_res_valid(b_res_valid),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
    } beat_t;

    beat_t       pipe [8];
    beat_t       src, out;
    logic [15:0] mem [32];
    logic        mem_load, pipe_clr, chain_en, frc_en, frc_v;
    logic [15:0] frc_a, frc_d;
    logic [3:0]  lat;

    always_comb begin
        src.v  = valid_o;
        src.rw = rw_o;
        src.a  = addr_o;
        src.wd = wdata_o;
        src.rd = mem[addr_o[4:0]];
    end

    always_comb begin
        if (lat == 4'd0) out = src;
        else             out = pipe[3'(lat - 4'd1)];
    end

    always @(posedge clk) begin
        if (pipe_clr) begin
            for (int k = 0; k < 8; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= src;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 32; k++) mem[k] <= 16'(k);
        end else if (valid_o && rw_o) begin
            mem[addr_o[4:0]] <= wdata_o;
        end
    end

    always_comb begin
        valid_i = frc_en ? frc_v : (chain_en & out.v);
        addr_i  = frc_en ? frc_a : out.a;
        wdata_i = frc_en ? frc_d : out.wd;
        rdata_i = frc_en ? frc_d : out.rd;
        rw_i    = frc_en ? 1'b0  : out.rw;
    end

    int    n_checks;
    int    n_fail;
    string tname;
    int    cyc;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // One clock: drive the valids for this cycle, then check handshake and pulse outputs.
    task automatic step(input logic av, input logic bv, input logic ear, input logic ebr,
                        input logic evo, input logic earv, input logic ebrv, input logic eto);
        string p;
        @(negedge clk);
        a_valid = av;
        b_valid = bv;
        #1;
        p = $sformatf("%s.c%0d.", tname, cyc);
        check({p, "a_ready"},     16'(a_ready),     16'(ear));
        check({p, "b_ready"},     16'(b_ready),     16'(ebr));
        check({p, "valid_o"},     16'(valid_o),     16'(evo));
        check({p, "a_res_valid"}, 16'(a_res_valid), 16'(earv));
        check({p, "b_res_valid"}, 16'(b_res_valid), 16'(ebrv));
        check({p, "timeout_o"},   16'(timeout_o),   16'(eto));
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic begin_test(input string name);
        tname = name;
        cyc   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check({tname, ".rst.a_ready"},     16'(a_ready),     16'h0);
        check({tname, ".rst.b_ready"},     16'(b_ready),     16'h0);
        check({tname, ".rst.valid_o"},     16'(valid_o),     16'h0);
        check({tname, ".rst.a_res_valid"}, 16'(a_res_valid), 16'h0);
        check({tname, ".rst.b_res_valid"}, 16'(b_res_valid), 16'h0);
        check({tname, ".rst.timeout_o"},   16'(timeout_o),   16'h0);
        check({tname, ".rst.addr_o"},      addr_o,           16'h0);
        check({tname, ".rst.wdata_o"},     wdata_o,          16'h0);
        check({tname, ".rst.rw_o"},        16'(rw_o),        16'h0);
        check({tname, ".rst.rdata_o"},     rdata_o,          16'h0);
        check({tname, ".rst.a_res_data"},  a_res_data,       16'h0);
        check({tname, ".rst.b_res_data"},  b_res_data,       16'h0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_addr = '0; a_data = '0; a_rw = 1'b0; a_valid = 1'b0;
        b_addr = '0; b_data = '0; b_rw = 1'b0; b_valid = 1'b0;
        mem_load = 1'b1; pipe_clr = 1'b1; chain_en = 1'b1;
        frc_en = 1'b0; frc_v = 1'b0; frc_a = '0; frc_d = '0;
        lat = 4'd1;

        begin_test("init");
        do_reset();
        mem_load = 1'b0;
        pipe_clr = 1'b0;

        // Write through a one-cycle chain: response three cycles after acceptance.
        begin_test("wr");
        a_addr = 16'h0001; a_data = 16'h5678; a_rw = 1'b1;
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("wr.addr_o",  addr_o,       16'h0001);
        check("wr.wdata_o", wdata_o,      16'h5678);
        check("wr.rw_o",    16'(rw_o),    16'h1);
        check("wr.rdata_o", rdata_o,      16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("wr.a_res_data", a_res_data, 16'h5678);
        check("wr.b_res_data", b_res_data, 16'h0000);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("wr.a_res_hold", a_res_data, 16'h5678);

        // Both request after reset: A first, B accepted as A's response pulses.
        begin_test("rr");
        do_reset();
        a_addr = 16'h0003; a_data = 16'h1111; a_rw = 1'b0;
        b_addr = 16'h0004; b_data = 16'h2222; b_rw = 1'b0;
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        check("rr.addr_a", addr_o, 16'h0003);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0, 0);
        check("rr.a_res_data", a_res_data, 16'h0003);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("rr.addr_b",  addr_o,  16'h0004);
        check("rr.wdata_b", wdata_o, 16'h2222);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("rr.b_res_data", b_res_data, 16'h0004);
        check("rr.a_res_hold", a_res_data, 16'h0003);
        idle(2);

        // A holds valid throughout, B asserts once: grants go A, B, A.
        begin_test("fair");
        a_addr = 16'h0005; b_addr = 16'h0006;
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1, 0, 0);
        check("fair.a_res_data", a_res_data, 16'h0005);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        check("fair.addr_b", addr_o, 16'h0006);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0);
        check("fair.b_res_data", b_res_data, 16'h0006);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("fair.addr_a2", addr_o, 16'h0005);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Silent chain: abort eight cycles after entering WAIT, then serve the next request.
        begin_test("tmo");
        a_addr = 16'h0009; a_rw = 1'b0;
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chain_en = 1'b0;
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(8);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        check("tmo.a_res_data", a_res_data, 16'h0000);
        chain_en = 1'b1;
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("tmo.addr_o", addr_o, 16'h0009);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("tmo.a_res_data2", a_res_data, 16'h0009);
        idle(2);

        // Response arrives in the very cycle the wait counter expires.
        begin_test("edge");
        lat = 4'd8;
        a_addr = 16'h000A;
        idle(1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(8);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("edge.a_res_data", a_res_data, 16'h000A);
        idle(2);

        // Reset while waiting: no response, everything cleared, late beat ignored.
        begin_test("rstw");
        lat = 4'd3;
        a_addr = 16'h0007; a_data = 16'hBEEF; a_rw = 1'b1;
        idle(1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("rstw.wdata_o", wdata_o, 16'hBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check("rstw.addr_o",     addr_o,     16'h0000);
        check("rstw.wdata_o0",   wdata_o,    16'h0000);
        check("rstw.rw_o",       16'(rw_o),  16'h0);
        check("rstw.a_res_data", a_res_data, 16'h0000);
        check("rstw.b_res_data", b_res_data, 16'h0000);
        idle(4);
        a_rw = 1'b0;

        // Stray beat in IDLE, then a wrong-address beat in WAIT; both must be ignored.
        begin_test("stray");
        lat = 4'd2;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        frc_en = 1'b1; frc_v = 1'b1; frc_a = 16'h0000; frc_d = 16'hDEAD;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        frc_en = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        a_addr = 16'h0010;
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("stray.addr_o", addr_o, 16'h0010);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        frc_en = 1'b1; frc_a = 16'h0011;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        frc_en = 1'b0;
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("stray.a_res_data", a_res_data, 16'h0010);
        idle(2);

        // Zero-latency chain: response sampled while still in ISSUE.
        begin_test("zl");
        lat = 4'd0;
        b_addr = 16'h0012; b_rw = 1'b0;
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("zl.b_res_data", b_res_data, 16'h0012);
        check("zl.a_res_hold", a_res_data, 16'h0010);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 255, SHALL be the maximum cycles to wait for a bus response before aborting.
REQ-002: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003: rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004: a_addr, a_data  input  16 each  SHALL carry requester A's address and write data.
REQ-005: a_rw  input  1  SHALL select requester A's operation: 1 = write, 0 = read.
REQ-006: a_valid  input  1; a_ready  output  1  SHALL form requester A's request handshake.
REQ-007: a_res_data  output  16; a_res_valid  output  1  SHALL carry requester A's response.
REQ-008: b_addr, b_data, b_rw, b_valid, b_ready, b_res_data, b_res_valid SHALL mirror the A ports for requester B.
REQ-009: addr_o, wdata_o, rdata_o (16 each), rw_o, valid_o (1 each)  outputs  SHALL drive the shared bus.
REQ-010: addr_i, wdata_i, rdata_i (16 each), rw_i, valid_i (1 each)  inputs  SHALL be the bus returning from the end of the core chain.
REQ-011: timeout_o  output  1  SHALL pulse for one cycle when a transaction is aborted by timeout.

Function
REQ-012: The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-013: a_ready is high only in IDLE with A granted; b_ready is high only in IDLE with B granted; at most one ready SHALL be high in any cycle.
REQ-014: Grant arbitration SHALL work as follows: only one valid -> grant it; both valid -> grant the requester not served last (round-robin); neither valid -> no grant.
REQ-015: Acceptance (x_valid & x_ready at cycle T) SHALL capture addr/data/rw and the owner ID, update last-served, and enter ISSUE at T+1.
REQ-016: In ISSUE the block SHALL drive valid_o=1 for exactly one cycle, with the captured addr_o/wdata_o/rw_o and rdata_o=0, then enter WAIT.
REQ-017: Outside ISSUE, valid_o SHALL be 0; addr_o/wdata_o/rw_o SHALL hold their last values and rdata_o SHALL be 0.
REQ-018: A response SHALL be valid_i=1 with addr_i equal to the captured address, sampled in ISSUE or WAIT, which covers zero-latency chains.
REQ-019: On a response at cycle R, at R+1 the owner's res_valid SHALL be 1 for one cycle, res_data SHALL equal rdata_i for reads or wdata_i for writes, and the FSM SHALL return to IDLE.
REQ-020: A new request MAY be accepted in the same cycle a res_valid pulse is high.
REQ-021: Total latency SHALL be res_valid at T+2+L, where L is the chain latency in cycles from valid_o to valid_i.
REQ-022: valid_i in IDLE, or with a non-matching addr_i, SHALL be ignored and produce no response.
REQ-023: A wait counter SHALL clear on entering ISSUE and increment each cycle in WAIT without a response.
REQ-024: When the wait counter reaches TIMEOUT, the next cycle SHALL drive owner res_valid=1 with res_data=0 and timeout_o=1, and the FSM SHALL go to IDLE.
REQ-025: If a response and timeout expiry coincide, the response SHALL take priority and timeout_o SHALL stay 0.
REQ-026: The non-owner's res_valid SHALL never pulse, and x_res_data SHALL hold its value when x_res_valid=0.
REQ-027: Requests SHALL never be dropped: a requester holding valid without ready SHALL be served at the next grant.

Reset
REQ-028: When rst is high, state SHALL go to IDLE; all ready/valid/res_valid/timeout_o outputs, all data outputs and the counter SHALL go to 0.
REQ-029: After reset, last-served SHALL be B, so A wins the first contention.
REQ-030: Reset in ISSUE or WAIT SHALL abort the transaction with no res_valid pulse, and a late matching valid_i SHALL then be ignored.

Verification
REQ-031: A write addr 0x0001 data 0x5678 through a 32-deep memory with L=1 -> valid_o one cycle, then a_res_valid at T+3 with a_res_data=0x5678.
REQ-032: A and B both valid after reset, reading 0x0003 and 0x0004 from memory preloaded mem[i]=i -> A served first with res 0x0003, then B with res 0x0004, and no overlap of valid_o.
REQ-033: A holds valid continuously and B asserts once -> grants alternate A, B, A, and B is not starved.
REQ-034: Chain never returns valid_i with TIMEOUT=8 -> res_valid with data 0x0000 and timeout_o pulse exactly 8 cycles after entering WAIT, then the FSM is in IDLE and accepts the next request.
REQ-035: rst asserted in WAIT, then a matching valid_i arrives -> no res_valid, and all outputs are 0.
REQ-036: Stray valid_i in IDLE, and a valid_i with mismatched addr in WAIT -> both ignored, and the correct response completes normally.
